// File: rtl/knn_topk_if.sv
// knn_topk_if: sample stream, result and list read port of the k-NN selector.
interface knn_topk_if #(parameter int DATA_W = 16, LABEL_W = 8, K = 4);
  logic                     start, valid, ready, last, done, rd_vld;
  logic [DATA_W-1:0]        dist_in, rd_dist;
  logic [LABEL_W-1:0]       label_in, result_label, rd_label;
  logic [$clog2(K+1)-1:0]   nb_count;
  logic [$clog2(K)-1:0]     rd_addr;
  modport master (output start, valid, dist_in, label_in, last, rd_addr,
                  input ready, done, result_label, nb_count, rd_dist, rd_label, rd_vld);
  modport slave  (input start, valid, dist_in, label_in, last, rd_addr,
                  output ready, done, result_label, nb_count, rd_dist, rd_label, rd_vld);
endinterface

// File: rtl/knn_topk.sv
// knn_topk: streaming sorted top-K distance list with majority vote (KNN_VOTE_EN) or 1-NN result.
module knn_topk #(parameter int DATA_W = 16, LABEL_W = 8, K = 4) (
  input logic clk,
  input logic rst,
  knn_topk_if.slave bus
);
  localparam int CW = $clog2(K+1);
  localparam int AW = $clog2(K);
`ifdef KNN_VOTE_EN
  typedef enum logic [1:0] {IDLE, LOAD, VOTE, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
`endif
  state_t              r_state, w_state_n;
  logic [DATA_W-1:0]   r_dist [K];
  logic [DATA_W-1:0]   w_dist_n [K];
  logic [LABEL_W-1:0]  r_label [K];
  logic [LABEL_W-1:0]  w_label_n [K];
  logic [K-1:0]        r_occ, w_occ_n, w_lt, w_first;
  logic [CW-1:0]       r_cnt;
  logic [LABEL_W-1:0]  r_result;
  logic                r_done, w_acc;
  assign w_acc         = r_state == LOAD && bus.valid && !bus.start;
  assign bus.ready     = r_state == LOAD;
  assign bus.done      = r_done;
  assign bus.nb_count  = r_cnt;
  assign bus.result_label = r_result;
  // sorted list keeps occupied entries as a prefix, so w_lt is monotone and w_first is one-hot
  assign w_first = w_lt & ~{w_lt[K-2:0], 1'b0};
  always_comb begin
    for (int i = 0; i < K; i++) begin
      w_lt[i]      = !r_occ[i] || bus.dist_in < r_dist[i];
      w_dist_n[i]  = r_dist[i];
      w_label_n[i] = r_label[i];
      w_occ_n[i]   = r_occ[i];
    end
    for (int i = 1; i < K; i++)
      if (w_acc && w_lt[i] && !w_first[i]) begin
        w_dist_n[i]  = r_dist[i-1];
        w_label_n[i] = r_label[i-1];
        w_occ_n[i]   = r_occ[i-1];
      end
    for (int i = 0; i < K; i++)
      if (w_acc && w_first[i]) begin
        w_dist_n[i]  = bus.dist_in;
        w_label_n[i] = bus.label_in;
        w_occ_n[i]   = 1'b1;
      end
  end
  always_comb begin
    bus.rd_dist  = '0;
    bus.rd_label = '0;
    bus.rd_vld   = 1'b0;
    for (int j = 0; j < K; j++)
      if (AW'(j) == bus.rd_addr) begin
        bus.rd_dist  = r_dist[j];
        bus.rd_label = r_label[j];
        bus.rd_vld   = r_occ[j];
      end
  end
`ifdef KNN_VOTE_EN
  logic [CW-1:0]      r_vi, r_best, w_votes;
  logic [LABEL_W-1:0] r_best_label, w_cand_label;
  logic               w_cand_occ, w_upd;
  always_comb begin
    w_cand_label = '0;
    w_cand_occ   = 1'b0;
    w_votes      = '0;
    for (int j = 0; j < K; j++)
      if (CW'(j) == r_vi) begin
        w_cand_label = r_label[j];
        w_cand_occ   = r_occ[j];
      end
    for (int j = 0; j < K; j++)
      w_votes = w_votes + CW'(r_occ[j] && r_label[j] == w_cand_label);
    w_upd = w_cand_occ && w_votes > r_best;
  end
`endif
  always_ff @(posedge clk)
    r_state <= rst ? IDLE : w_state_n;
  always_comb begin
    w_state_n = r_state;
    if (bus.start)
      w_state_n = LOAD;
    else if (r_state == LOAD && w_acc && bus.last)
`ifdef KNN_VOTE_EN
      w_state_n = VOTE;
    else if (r_state == VOTE && r_vi == CW'(K-1))
      w_state_n = DONE;
`else
      w_state_n = DONE;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_occ    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
`ifdef KNN_VOTE_EN
      r_vi         <= '0;
      r_best       <= '0;
      r_best_label <= '0;
`endif
    end else if (bus.start) begin
      r_occ  <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
`ifdef KNN_VOTE_EN
      r_vi         <= '0;
      r_best       <= '0;
      r_best_label <= '0;
`endif
    end else begin
      r_dist  <= w_dist_n;
      r_label <= w_label_n;
      r_occ   <= w_occ_n;
      r_done  <= r_state == DONE;
      if (w_acc && !r_occ[K-1])
        r_cnt <= r_cnt + CW'(1);
`ifdef KNN_VOTE_EN
      if (r_state == VOTE) begin
        r_vi <= r_vi + CW'(1);
        if (w_upd) begin
          r_best       <= w_votes;
          r_best_label <= w_cand_label;
        end
        if (r_vi == CW'(K-1))
          r_result <= w_upd ? w_cand_label : r_best_label;
      end
`else
      if (w_acc && bus.last)
        r_result <= w_label_n[0];
`endif
    end
  end
endmodule

// File: tb/tb_knn_topk.sv
// tb_knn_topk: directed checks of knn_topk in either build (KNN_VOTE_EN defined or not).
module tb_knn_topk;
  localparam int DW = 16, LW = 8, K = 4;
`ifdef KNN_VOTE_EN
  localparam int LAT = K + 1;
`else
  localparam int LAT = 1;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errs = 0, checks = 0;
  always #5 clk = ~clk;
  knn_topk_if #(.DATA_W(DW), .LABEL_W(LW), .K(K)) bus();
  knn_topk #(.DATA_W(DW), .LABEL_W(LW), .K(K)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    bus.start = 1'b1;
    step;
    bus.start = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [LW-1:0] l, input logic lst);
    bus.valid = 1'b1;
    bus.dist_in = d;
    bus.label_in = l;
    bus.last = lst;
    step;
    bus.valid = 1'b0;
    bus.last = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step;
    step;
    rst = 1'b0;
    checks++;
    if (bus.ready !== 1'b0 || bus.done !== 1'b0 || bus.result_label !== 8'd0 || bus.nb_count !== 3'd0) begin
      errs++;
      $display("FAIL reset_outputs: got ready=%b done=%b res=%0d cnt=%0d, want 0 0 0 0", bus.ready, bus.done, bus.result_label, bus.nb_count);
    end
    for (int a = 0; a < K; a++) begin
      bus.rd_addr = a[1:0];
      #1;
      checks++;
      if (bus.rd_vld !== 1'b0) begin
        errs++;
        $display("FAIL reset_rd_vld%0d: got %b want 0", a, bus.rd_vld);
      end
    end
    step;
    checks++;
    if (bus.ready !== 1'b0) begin
      errs++;
      $display("FAIL idle_ready: got %b want 0", bus.ready);
    end
  endtask

  task automatic test_sorted_insert;
    logic [DW-1:0] ed [K] = '{16'd5, 16'd10, 16'd30, 16'd50};
    logic [LW-1:0] el [K] = '{8'd5, 8'd2, 8'd3, 8'd1};
    pulse_start;
    checks++;
    if (bus.ready !== 1'b1) begin
      errs++;
      $display("FAIL load_ready: got %b want 1", bus.ready);
    end
    send(16'd50, 8'd1, 1'b0);
    bus.rd_addr = 2'd0;
    #1;
    checks++;
    if (bus.rd_vld !== 1'b1 || bus.rd_dist !== 16'd50 || bus.nb_count !== 3'd1) begin
      errs++;
      $display("FAIL first_insert: got v=%b d=%0d cnt=%0d, want v=1 d=50 cnt=1", bus.rd_vld, bus.rd_dist, bus.nb_count);
    end
    send(16'd10, 8'd2, 1'b0);
    send(16'd30, 8'd3, 1'b0);
    send(16'd70, 8'd4, 1'b0);
    send(16'd5, 8'd5, 1'b1);
    checks++;
    if (bus.done !== 1'b0 || bus.ready !== 1'b0 || bus.nb_count !== 3'd4) begin
      errs++;
      $display("FAIL after_last: got done=%b ready=%b cnt=%0d, want 0 0 4", bus.done, bus.ready, bus.nb_count);
    end
    for (int a = 0; a < K; a++) begin
      bus.rd_addr = a[1:0];
      #1;
      checks++;
      if (bus.rd_vld !== 1'b1 || bus.rd_dist !== ed[a] || bus.rd_label !== el[a]) begin
        errs++;
        $display("FAIL sorted_entry%0d: got v=%b d=%0d l=%0d, want v=1 d=%0d l=%0d", a, bus.rd_vld, bus.rd_dist, bus.rd_label, ed[a], el[a]);
      end
    end
    for (int c = 0; c < LAT - 1; c++) step;
    checks++;
    if (bus.done !== 1'b0) begin
      errs++;
      $display("FAIL sorted_done_early: got %b want 0", bus.done);
    end
    step;
    checks++;
    if (bus.done !== 1'b1 || bus.result_label !== 8'd5) begin
      errs++;
      $display("FAIL sorted_result: got done=%b res=%0d, want done=1 res=5", bus.done, bus.result_label);
    end
    step;
    step;
    checks++;
    if (bus.done !== 1'b1 || bus.ready !== 1'b0) begin
      errs++;
      $display("FAIL done_hold: got done=%b ready=%b, want 1 0", bus.done, bus.ready);
    end
  endtask

  task automatic test_tie;
    pulse_start;
    send(16'd20, 8'd7, 1'b0);
    send(16'd20, 8'd9, 1'b1);
    bus.rd_addr = 2'd0;
    #1;
    checks++;
    if (bus.rd_label !== 8'd7 || bus.rd_vld !== 1'b1) begin
      errs++;
      $display("FAIL tie_idx0: got l=%0d v=%b, want l=7 v=1", bus.rd_label, bus.rd_vld);
    end
    bus.rd_addr = 2'd1;
    #1;
    checks++;
    if (bus.rd_label !== 8'd9 || bus.rd_vld !== 1'b1) begin
      errs++;
      $display("FAIL tie_idx1: got l=%0d v=%b, want l=9 v=1", bus.rd_label, bus.rd_vld);
    end
    bus.rd_addr = 2'd2;
    #1;
    checks++;
    if (bus.rd_vld !== 1'b0 || bus.nb_count !== 3'd2) begin
      errs++;
      $display("FAIL tie_count: got v2=%b cnt=%0d, want v2=0 cnt=2", bus.rd_vld, bus.nb_count);
    end
  endtask

  task automatic test_vote;
    logic [LW-1:0] exp_maj;
`ifdef KNN_VOTE_EN
    exp_maj = 8'd8;
`else
    exp_maj = 8'd6;
`endif
    pulse_start;
    send(16'd10, 8'd3, 1'b0);
    send(16'd20, 8'd4, 1'b0);
    send(16'd30, 8'd4, 1'b0);
    send(16'd40, 8'd3, 1'b1);
    for (int c = 0; c < LAT - 1; c++) step;
    checks++;
    if (bus.done !== 1'b0) begin
      errs++;
      $display("FAIL tie_vote_early: got done=%b want 0", bus.done);
    end
    step;
    checks++;
    if (bus.done !== 1'b1 || bus.result_label !== 8'd3) begin
      errs++;
      $display("FAIL tie_vote: got done=%b res=%0d, want done=1 res=3", bus.done, bus.result_label);
    end
    pulse_start;
    send(16'd10, 8'd6, 1'b0);
    send(16'd20, 8'd8, 1'b0);
    send(16'd30, 8'd8, 1'b0);
    send(16'd40, 8'd2, 1'b1);
    for (int c = 0; c < LAT; c++) step;
    checks++;
    if (bus.done !== 1'b1 || bus.result_label !== exp_maj) begin
      errs++;
      $display("FAIL majority: got done=%b res=%0d, want done=1 res=%0d", bus.done, bus.result_label, exp_maj);
    end
  endtask

  task automatic test_full_reject;
    pulse_start;
    send(16'd1, 8'd11, 1'b0);
    send(16'd2, 8'd12, 1'b0);
    send(16'd3, 8'd13, 1'b0);
    send(16'd4, 8'd14, 1'b0);
    send(16'd9, 8'd19, 1'b0);
    bus.rd_addr = 2'd3;
    #1;
    checks++;
    if (bus.rd_dist !== 16'd4 || bus.rd_label !== 8'd14 || bus.nb_count !== 3'd4) begin
      errs++;
      $display("FAIL full_reject: got d=%0d l=%0d cnt=%0d, want d=4 l=14 cnt=4", bus.rd_dist, bus.rd_label, bus.nb_count);
    end
    send(16'd0, 8'd15, 1'b0);
    bus.rd_addr = 2'd0;
    #1;
    checks++;
    if (bus.rd_dist !== 16'd0 || bus.rd_label !== 8'd15) begin
      errs++;
      $display("FAIL full_insert_head: got d=%0d l=%0d, want d=0 l=15", bus.rd_dist, bus.rd_label);
    end
    bus.rd_addr = 2'd3;
    #1;
    checks++;
    if (bus.rd_dist !== 16'd3 || bus.rd_label !== 8'd13 || bus.nb_count !== 3'd4) begin
      errs++;
      $display("FAIL full_discard: got d=%0d l=%0d cnt=%0d, want d=3 l=13 cnt=4", bus.rd_dist, bus.rd_label, bus.nb_count);
    end
  endtask

  task automatic test_priority;
    pulse_start;
    bus.start = 1'b1;
    bus.valid = 1'b1;
    bus.dist_in = 16'd1;
    bus.label_in = 8'd1;
    step;
    bus.start = 1'b0;
    bus.valid = 1'b0;
    bus.rd_addr = 2'd0;
    #1;
    checks++;
    if (bus.nb_count !== 3'd0 || bus.rd_vld !== 1'b0 || bus.ready !== 1'b1) begin
      errs++;
      $display("FAIL start_priority: got cnt=%0d v=%b ready=%b, want 0 0 1", bus.nb_count, bus.rd_vld, bus.ready);
    end
  endtask

  task automatic test_abort;
    logic seen;
    seen = 1'b0;
    pulse_start;
    send(16'd10, 8'd1, 1'b1);
`ifdef KNN_VOTE_EN
    step;
    checks++;
    if (bus.done !== 1'b0 || bus.ready !== 1'b0) begin
      errs++;
      $display("FAIL in_vote: got done=%b ready=%b, want 0 0", bus.done, bus.ready);
    end
`endif
    pulse_start;
    for (int c = 0; c < K + 3; c++) begin
      seen |= bus.done;
      step;
    end
    checks++;
    if (seen !== 1'b0 || bus.ready !== 1'b1 || bus.nb_count !== 3'd0) begin
      errs++;
      $display("FAIL abort: got done_seen=%b ready=%b cnt=%0d, want 0 1 0", seen, bus.ready, bus.nb_count);
    end
  endtask

  task automatic test_mid_reset;
    pulse_start;
    send(16'd7, 8'd2, 1'b0);
    rst = 1'b1;
    step;
    rst = 1'b0;
    bus.rd_addr = 2'd0;
    #1;
    checks++;
    if (bus.nb_count !== 3'd0 || bus.ready !== 1'b0 || bus.rd_vld !== 1'b0 || bus.result_label !== 8'd0) begin
      errs++;
      $display("FAIL mid_reset: got cnt=%0d ready=%b v=%b res=%0d, want 0 0 0 0", bus.nb_count, bus.ready, bus.rd_vld, bus.result_label);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.valid = 1'b0;
    bus.last = 1'b0;
    bus.dist_in = '0;
    bus.label_in = '0;
    bus.rd_addr = '0;
    test_reset;
    test_sorted_insert;
    test_tie;
    test_vote;
    test_full_reject;
    test_priority;
    test_abort;
    test_mid_reset;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
